// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register responder.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACCESS = 3'd1,
    ST_WR_RESP   = 3'd2,
    ST_RD_ACCESS = 3'd3,
    ST_RD_RESP   = 3'd4
  } state_t;

  // Byte offset bits within a word; ignored for decode.
  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/axi4_lite_resp_timeout.sv
// Down-counting access watchdog: loaded on start, counts while run is high,
// flags expiry in the TIMEOUT-th running cycle.
module axi4_lite_resp_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Load on grant, drop to zero when idle, otherwise count down to terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/axi4_lite_reg_responder.sv
// AXI4-Lite slave that turns bus transactions into single native register
// accesses with variable-latency acknowledge and a watchdog.
//
// state        | meaning
// ST_IDLE      | waiting for a complete write (AW+W) or a read (AR)
// ST_WR_ACCESS | reg_req high for a write, waiting for reg_ack
// ST_WR_RESP   | BVALID high, waiting for BREADY
// ST_RD_ACCESS | reg_req high for a read, waiting for reg_ack
// ST_RD_RESP   | RVALID high, waiting for RREADY
module axi4_lite_reg_responder
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    STROB_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WIN_WORDS   = 256,
  parameter int                    TIMEOUT     = 64
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [2:0]                   AWPROT,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [STROB_WIDTH-1:0]       WSTRB,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [ADDR_WIDTH-1:0]        ARADDR,
  input  logic [2:0]                   ARPROT,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [DATA_WIDTH-1:0]        RDATA,
  output logic [1:0]                   RRESP,
  output logic                         reg_req,
  output logic                         reg_we,
  output logic [$clog2(WIN_WORDS)-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]        reg_wdata,
  output logic [STROB_WIDTH-1:0]       reg_wstrb,
  input  logic                         reg_ack,
  input  logic                         reg_err,
  input  logic [DATA_WIDTH-1:0]        reg_rdata
);

  localparam int IDX_W   = $clog2(WIN_WORDS);
  localparam int TAG_LSB = ADDR_LSB + IDX_W;

  state_t                  state;
  resp_t                   resp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    live;
  logic                    last_rd;

  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STROB_WIDTH-1:0]  w_strb;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_pend, rd_pend, grant_rd, grant_wr, wr_in, rd_in;
  logic in_access, tmr_start, tmr_run, tmr_expired;
  logic unused_bits;

  // BASE_ADDR is window-aligned, so the upper address bits alone decide hits.
  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB];
  endfunction

  assign unused_bits = ^{AWPROT, ARPROT, aw_addr[ADDR_LSB-1:0], ar_addr[ADDR_LSB-1:0]};

  // READYs stay low during reset and the first cycle after it.
  assign AWREADY = live && !aw_full;
  assign WREADY  = live && !w_full;
  assign ARREADY = live && !ar_full && (state != ST_RD_ACCESS) && (state != ST_RD_RESP);
  assign BVALID  = (state == ST_WR_RESP);
  assign RVALID  = (state == ST_RD_RESP);
  assign BRESP   = resp_q;
  assign RRESP   = resp_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign b_hs  = BVALID && BREADY;
  assign r_hs  = RVALID && RREADY;

  // Round-robin only matters when both sides are waiting; read wins after reset.
  assign wr_pend  = aw_full && w_full;
  assign rd_pend  = ar_full;
  assign grant_rd = rd_pend && (!wr_pend || !last_rd);
  assign grant_wr = wr_pend && !grant_rd;
  assign wr_in    = in_win(aw_addr);
  assign rd_in    = in_win(ar_addr);

  assign in_access = (state == ST_WR_ACCESS) || (state == ST_RD_ACCESS);
  assign tmr_start = (state == ST_IDLE) && ((grant_wr && wr_in) || (grant_rd && rd_in));
  assign tmr_run   = in_access && !reg_ack;

  axi4_lite_resp_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (ACLK),
    .rst     (ARESET),
    .start   (tmr_start),
    .clear   (!in_access),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  // Ready gating: hold READYs low until the first clock after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  // One-entry holding slots for AW, W and AR; emptied by the matching response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end else if (b_hs) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end else if (b_hs) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= ARADDR;
      end else if (r_hs) begin
        ar_full <= 1'b0;
      end
    end
  end

  // Responder FSM: grant, native access with ack/timeout, then bus response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      resp_q    <= OKAY;
      rdata_q   <= '0;
      last_rd   <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            if (wr_pend) last_rd <= 1'b1;
            if (rd_in) begin
              state    <= ST_RD_ACCESS;
              reg_req  <= 1'b1;
              reg_we   <= 1'b0;
              reg_addr <= ar_addr[TAG_LSB-1:ADDR_LSB];
            end else begin
              state   <= ST_RD_RESP;
              resp_q  <= DECERR;
              rdata_q <= '0;
            end
          end else if (grant_wr) begin
            if (rd_pend) last_rd <= 1'b0;
            if (wr_in) begin
              state     <= ST_WR_ACCESS;
              reg_req   <= 1'b1;
              reg_we    <= 1'b1;
              reg_addr  <= aw_addr[TAG_LSB-1:ADDR_LSB];
              reg_wdata <= w_data;
              reg_wstrb <= w_strb;
            end else begin
              state  <= ST_WR_RESP;
              resp_q <= DECERR;
            end
          end
        end
        ST_WR_ACCESS: begin
          if (reg_ack) begin
            resp_q  <= reg_err ? SLVERR : OKAY;
            reg_req <= 1'b0;
            state   <= ST_WR_RESP;
          end else if (tmr_expired) begin
            resp_q  <= SLVERR;
            reg_req <= 1'b0;
            state   <= ST_WR_RESP;
          end
        end
        ST_RD_ACCESS: begin
          if (reg_ack) begin
            resp_q  <= reg_err ? SLVERR : OKAY;
            rdata_q <= reg_rdata;
            reg_req <= 1'b0;
            state   <= ST_RD_RESP;
          end else if (tmr_expired) begin
            resp_q  <= SLVERR;
            rdata_q <= '0;
            reg_req <= 1'b0;
            state   <= ST_RD_RESP;
          end
        end
        ST_WR_RESP: if (BREADY) state <= ST_IDLE;
        ST_RD_RESP: if (RREADY) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_responder.sv
// Directed bench for axi4_lite_reg_responder with a simple native-side responder.
module tb_axi4_lite_reg_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam logic [1:0] R_OKAY = 2'b00;
  localparam logic [1:0] R_SLV  = 2'b10;
  localparam logic [1:0] R_DEC  = 2'b11;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          AWVALID = 1'b0, AWREADY;
  logic [AW-1:0] AWADDR = '0;
  logic [2:0]    AWPROT = '0;
  logic          WVALID = 1'b0, WREADY;
  logic [DW-1:0] WDATA = '0;
  logic [SW-1:0] WSTRB = '0;
  logic          BVALID, BREADY = 1'b0;
  logic [1:0]    BRESP;
  logic          ARVALID = 1'b0, ARREADY;
  logic [AW-1:0] ARADDR = '0;
  logic [2:0]    ARPROT = '0;
  logic          RVALID, RREADY = 1'b0;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          reg_req, reg_we;
  logic [IW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic          reg_ack = 1'b0;
  logic          reg_err = 1'b0;
  logic [DW-1:0] reg_rdata = '0;

  int total = 0;
  int bad = 0;

  // native-side responder state
  int            ack_lat = 1;
  logic          spur_ack = 1'b0;
  int            acc_cnt = 0;
  int            req_run = 0;
  int            req_hi = 0;
  logic          req_prev = 1'b0;
  logic [IW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;
  logic          cap_we = 1'b0;
  logic          acc_we_q[$];

  axi4_lite_reg_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Acks the ack_lat-th cycle of each reg_req (0 = never) and logs each access.
  always @(negedge ACLK) begin
    reg_ack = spur_ack;
    if (reg_req) begin
      if (!req_prev) begin
        acc_cnt++;
        req_run = 0;
        cap_addr = reg_addr;
        cap_wdata = reg_wdata;
        cap_wstrb = reg_wstrb;
        cap_we = reg_we;
        acc_we_q.push_back(reg_we);
      end
      req_run++;
      req_hi++;
      if (ack_lat != 0 && req_run == ack_lat) reg_ack = 1'b1;
    end
    req_prev = reg_req;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_xfer(input logic [AW-1:0] a);
    int n = 0;
    @(negedge ACLK);
    AWADDR = a;
    AWVALID = 1'b1;
    while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("aw_handshake", n < 100, 1);
    @(posedge ACLK);
    #1 AWVALID = 1'b0;
  endtask

  task automatic w_xfer(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    @(negedge ACLK);
    WDATA = d;
    WSTRB = s;
    WVALID = 1'b1;
    while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("w_handshake", n < 100, 1);
    @(posedge ACLK);
    #1 WVALID = 1'b0;
  endtask

  task automatic ar_xfer(input logic [AW-1:0] a);
    int n = 0;
    @(negedge ACLK);
    ARADDR = a;
    ARVALID = 1'b1;
    while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("ar_handshake", n < 100, 1);
    @(posedge ACLK);
    #1 ARVALID = 1'b0;
  endtask

  task automatic get_b(input string tag, input int hold, input logic [1:0] exp);
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!BVALID && n < 300);
    chk({tag, "_bvalid_wait"}, n < 300, 1);
    chk({tag, "_bresp"}, BRESP, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk({tag, "_bvalid_hold"}, BVALID, 1);
      chk({tag, "_bresp_hold"}, BRESP, exp);
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    #1 BREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, "_bvalid_once"}, BVALID, 0);
  endtask

  task automatic get_r(input string tag, input logic [1:0] exp_resp,
                       input logic [DW-1:0] exp_data, output int lat);
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!RVALID && n < 300);
    lat = n;
    chk({tag, "_rvalid_wait"}, n < 300, 1);
    chk({tag, "_rresp"}, RRESP, exp_resp);
    chk({tag, "_rdata"}, RDATA, exp_data);
    RREADY = 1'b1;
    @(posedge ACLK);
    #1 RREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, "_rvalid_once"}, RVALID, 0);
  endtask

  initial begin
    int base;
    int lat, lat2;

    // reset values
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_resp", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_reg_req", reg_req, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_fields", {reg_addr, reg_wdata, reg_wstrb}, 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    // write DEADBEEF to BASE+8, ack in 3rd request cycle
    ack_lat = 3; reg_err = 1'b0; req_hi = 0; base = acc_cnt;
    fork
      aw_xfer(32'h8);
      w_xfer(32'hDEADBEEF, 4'hF);
      get_b("t1", 0, R_OKAY);
    join
    chk("t1_acc_cnt", acc_cnt, base + 1);
    chk("t1_reg_addr", cap_addr, 2);
    chk("t1_reg_wdata", cap_wdata, 32'hDEADBEEF);
    chk("t1_reg_wstrb", cap_wstrb, 4'hF);
    chk("t1_reg_we", cap_we, 1);
    chk("t1_req_cycles", req_hi, 3);

    // W two cycles ahead of AW, WSTRB=0
    ack_lat = 2; base = acc_cnt;
    w_xfer(32'h0BADF00D, 4'h0);
    @(negedge ACLK);
    chk("t2_no_req_a", reg_req, 0);
    chk("t2_wready_full", WREADY, 0);
    @(negedge ACLK);
    chk("t2_no_req_b", reg_req, 0);
    fork
      aw_xfer(32'h4);
      get_b("t2", 0, R_OKAY);
    join
    chk("t2_acc_cnt", acc_cnt, base + 1);
    chk("t2_reg_addr", cap_addr, 1);
    chk("t2_reg_wdata", cap_wdata, 32'h0BADF00D);
    chk("t2_reg_wstrb", cap_wstrb, 4'h0);

    // read BASE+0x10 with target error, minimum latency
    ack_lat = 1; reg_err = 1'b1; reg_rdata = 32'h12345678; base = acc_cnt;
    ar_xfer(32'h10);
    get_r("t3", R_SLV, 32'h12345678, lat);
    chk("t3_latency", lat, 3);
    chk("t3_reg_addr", cap_addr, 4);
    chk("t3_reg_we", cap_we, 0);
    chk("t3_acc_cnt", acc_cnt, base + 1);

    // stray ack with no request, then out-of-window read
    reg_err = 1'b0; base = acc_cnt;
    spur_ack = 1'b1;
    repeat (3) @(negedge ACLK);
    spur_ack = 1'b0;
    chk("t4_stray_ack_valid", {BVALID, RVALID, reg_req}, 3'b000);
    ar_xfer(32'h400);
    get_r("t4", R_DEC, 32'h0, lat);
    chk("t4_no_access", acc_cnt, base);

    // no ack: timeout after 64 request cycles
    ack_lat = 0; reg_rdata = 32'hAAAA5555; req_hi = 0;
    ar_xfer(32'h20);
    get_r("t5", R_SLV, 32'h0, lat);
    chk("t5_req_cycles", req_hi, 64);
    chk("t5_req_low", reg_req, 0);

    // ack arriving exactly in the timeout cycle wins
    ack_lat = 64; reg_rdata = 32'hCAFEF00D; req_hi = 0;
    ar_xfer(32'h24);
    get_r("t5b", R_OKAY, 32'hCAFEF00D, lat);
    chk("t5b_req_cycles", req_hi, 64);

    // normal write after timeout
    ack_lat = 1; base = acc_cnt;
    fork
      aw_xfer(32'h30);
      w_xfer(32'h00005A5A, 4'h3);
      get_b("t5c", 0, R_OKAY);
    join
    chk("t5c_reg_addr", cap_addr, 8'h0C);
    chk("t5c_acc_cnt", acc_cnt, base + 1);

    // reset in the middle of an access
    ack_lat = 0;
    ar_xfer(32'h50);
    repeat (3) @(negedge ACLK);
    chk("t6_req_before_rst", reg_req, 1);
    #2 ARESET = 1'b1;
    #1;
    chk("t6_req_async_drop", reg_req, 0);
    chk("t6_valids_async", {BVALID, RVALID}, 2'b00);
    chk("t6_arready_rst", ARREADY, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    ack_lat = 1;
    repeat (2) @(negedge ACLK);
    chk("t6_slots_empty", {AWREADY, WREADY, ARREADY, reg_req}, 4'b1110);

    // simultaneous AR and AW+W after reset: read first
    reg_err = 1'b0; reg_rdata = 32'h55667788;
    acc_we_q.delete();
    fork
      aw_xfer(32'h40);
      w_xfer(32'h11111111, 4'hF);
      ar_xfer(32'h44);
      get_b("t7w", 0, R_OKAY);
      get_r("t7r", R_OKAY, 32'h55667788, lat);
    join
    chk("t7_two_accesses", acc_we_q.size(), 2);
    chk("t7_first_is_read", acc_we_q[0], 0);
    chk("t7_second_is_write", acc_we_q[1], 1);

    // repeat simultaneously: write first, BREADY held off 5 cycles
    reg_err = 1'b1; reg_rdata = 32'h77778888;
    acc_we_q.delete();
    fork
      aw_xfer(32'h48);
      w_xfer(32'h22222222, 4'hF);
      ar_xfer(32'h4C);
      get_b("t8w", 5, R_SLV);
      get_r("t8r", R_SLV, 32'h77778888, lat2);
    join
    chk("t8_two_accesses", acc_we_q.size(), 2);
    chk("t8_first_is_write", acc_we_q[0], 1);
    chk("t8_second_is_read", acc_we_q[1], 0);
    chk("t8_last_addr", cap_addr, 8'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_lite_reg_responder.md
Name: axi4_lite_reg_responder

Overview:
- AXI4-Lite slave endpoint that converts bus transactions into a single-port native register access interface with variable-latency acknowledge.
- Sits on the responder end of the axi4_lite master/slave interconnect, in front of peripheral register banks.
- Decodes an address window, arbitrates reads against writes, and returns OKAY, SLVERR or DECERR.
- Produces SLVERR when the target sets reg_err or fails to acknowledge within a timeout.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width (multiple of 8)
STROB_WIDTH, 4, DATA_WIDTH/8
BASE_ADDR, 32'h0000_0000, window base (aligned to window size)
WIN_WORDS, 256, window size in words (power of 2)
TIMEOUT, 64, max cycles waiting for reg_ack (>=2)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
AWVALID/AWREADY  in/out  1  write address handshake
AWADDR  in  ADDR_WIDTH  write address
AWPROT  in  3  ignored
WVALID/WREADY  in/out  1  write data handshake
WDATA  in  DATA_WIDTH  write data
WSTRB  in  STROB_WIDTH  byte strobes
BVALID/BREADY  out/in  1  write response handshake
BRESP  out  2  write response
ARVALID/ARREADY  in/out  1  read address handshake
ARADDR  in  ADDR_WIDTH  read address
ARPROT  in  3  ignored
RVALID/RREADY  out/in  1  read data handshake
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
reg_req  out  1  native access request, held until reg_ack or timeout
reg_we  out  1  1=write, 0=read; valid with reg_req
reg_addr  out  $clog2(WIN_WORDS)  word index = (addr-BASE_ADDR)>>2
reg_wdata  out  DATA_WIDTH  write data
reg_wstrb  out  STROB_WIDTH  byte enables
reg_ack  in  1  access complete
reg_err  in  1  target error, sampled with reg_ack
reg_rdata  in  DATA_WIDTH  read data, sampled with reg_ack

Behaviour:
- Reset values: all READY/VALID outputs 0, BRESP=RRESP=2'b00, RDATA=0, reg_req=0, reg_we=0, reg_addr/reg_wdata/reg_wstrb=0; FSM to IDLE; counter 0; arbiter favours read.
- AW and W accepted independently into one-entry holding registers. AWREADY=1 while the AW slot is empty, WREADY=1 while the W slot is empty. A write is pending when both slots are full. ARREADY=1 while the AR slot is empty and the FSM is not in RD_ACCESS/RD_RESP.
- Address low 2 bits are ignored. An address is out of window if outside [BASE_ADDR, BASE_ADDR+4*WIN_WORDS).
- FSM states: IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP.
- IDLE:
  - Only a write pending -> WR_ACCESS. Only AR held -> RD_ACCESS.
  - Both pending -> grant the side not served last (round-robin), then update the last-served bit.
  - Out-of-window access -> no reg_req; go directly to WR_RESP/RD_RESP with DECERR (2'b11), RDATA=0.
- WR_ACCESS/RD_ACCESS:
  - reg_req=1 with stable reg_we/addr/wdata/wstrb from the cycle after grant.
  - reg_ack=1 -> register resp = reg_err ? SLVERR (2'b10) : OKAY; on read, latch reg_rdata; next state *_RESP.
  - Counter increments each cycle without ack. At TIMEOUT -> SLVERR, RDATA=0, drop reg_req.
  - reg_req deasserts the cycle after ack.
- WR_RESP: BVALID=1 with BRESP held until BREADY. On handshake: clear AW/W slots -> IDLE.
- RD_RESP: RVALID=1 with RDATA/RRESP held until RREADY. On handshake: clear AR slot -> IDLE.
- Minimum latency: AW+W (or AR) accepted at cycle 0, reg_req at cycle 2, reg_ack same cycle -> B/R valid at cycle 3.
- Boundary conditions:
  - reg_ack while reg_req=0 is ignored.
  - reg_ack in the same cycle the timeout fires: ack wins.
  - New AW/W/AR may be accepted into empty slots while another transaction is in progress; responses are never reordered relative to the grant.
  - WSTRB=0 still issues an access with reg_wstrb=0.
- ARESET mid-access drops reg_req and all VALIDs immediately (async) and discards held transactions.

Decomposition:
- Package axi4_lite_pkg:
  - resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}
  - responder state enum
  - ADDR_LSB=2 constant
- Sub-module axi4_lite_resp_timeout: counter with start, clear and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Write 32'hDEADBEEF, WSTRB=4'hF to BASE_ADDR+8, reg_ack after 3 cycles, err=0 -> reg_addr=2, reg_wdata=DEADBEEF, BRESP=OKAY, one BVALID.
- W phase 2 cycles before AW, addr BASE+4 -> no reg_req until AW arrives; then a single access with reg_addr=1.
- Read BASE+0x10, reg_rdata=32'h12345678, reg_err=1 -> RDATA=12345678, RRESP=SLVERR.
- Read BASE+4*WIN_WORDS -> no reg_req, RRESP=DECERR, RDATA=0.
- Read with reg_ack never asserted -> reg_req drops after TIMEOUT=64 cycles, RRESP=SLVERR; then a write completes normally.
- AR and AW+W in the same cycle after reset -> read served first, then write. Repeat simultaneously -> write first (round-robin). BREADY held low 5 cycles -> BVALID/BRESP stable throughout.
